mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. Only one access is outstanding at a time. Data wins by default,
// and a fetch is forced through after MAX_D_STREAK back-to-back data grants.
// A branch redirect cancels the fetch result but never aborts the memory
// access. An access that waits TIMEOUT cycles is dropped and bus_err pulses.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req, if_addr, b_taken     fetch request, word address, branch cancel
//   d_req, d_we, d_addr,
//   d_wdata, d_be                load/store request
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be            shared memory port (registered, held per access)
//   mem_ready, mem_rdata         memory completion strobe and read data
//   if_valid, if_rdata           registered fetch result (one-cycle valid)
//   d_valid, d_rdata             registered data result (one-cycle valid)
//   stall_if, stall_mem          combinational hold requests
//   bus_err                      one-cycle pulse on timeout
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        b_taken,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int unsigned StreakW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int unsigned WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [31:0]         if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                cancel_q, cancel_d;

  logic fetch_ok, grant_if, grant_d, done, timeout;

  // A redirect in the same cycle makes the presented fetch address stale.
  assign fetch_ok = if_req & ~b_taken;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and grant/completion decode.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(fetch_ok && streak_q == StreakW'(MAX_D_STREAK))) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (fetch_ok) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping counters.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
    streak_d    = streak_q;
    wait_d      = wait_q;
    cancel_d    = cancel_q;
    if (grant_d) begin
      mem_req_d   = 1'b1;
      mem_we_d    = d_we;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      mem_be_d    = d_be;
      wait_d      = '0;
      cancel_d    = 1'b0;
      // Streak only grows while a fetch is actually being held off.
      if (!if_req)                                    streak_d = '0;
      else if (streak_q != StreakW'(MAX_D_STREAK))    streak_d = streak_q + StreakW'(1);
    end else if (grant_if) begin
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_be_d    = 4'hF;
      wait_d      = '0;
      cancel_d    = 1'b0;
      streak_d    = '0;
    end else if (done) begin
      mem_req_d = 1'b0;
      wait_d    = '0;
      cancel_d  = 1'b0;
      if (state_q == D_BUSY) begin
        d_rdata_d = mem_rdata;
        d_valid_d = 1'b1;
      end else if (!(cancel_q || b_taken)) begin
        if_rdata_d = mem_rdata;
        if_valid_d = 1'b1;
      end
    end else if (timeout) begin
      mem_req_d = 1'b0;
      bus_err_d = 1'b1;
      wait_d    = '0;
      cancel_d  = 1'b0;
    end else if (state_q != IDLE) begin
      wait_d = wait_q + WaitW'(1);
      if (state_q == IF_BUSY && b_taken) cancel_d = 1'b1;
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      streak_q    <= '0;
      wait_q      <= '0;
      cancel_q    <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      cancel_q    <= cancel_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

  // A cancelled fetch completing does not release the fetch stage.
  assign stall_if  = if_req & ~((state_q == IF_BUSY) & mem_ready & ~cancel_q & ~b_taken);
  assign stall_mem = d_req  & ~((state_q == D_BUSY) & mem_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, b_taken, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        mem_req, mem_we, if_valid, d_valid, stall_if, stall_mem, bus_err;
  logic [31:0] mem_addr, mem_wdata, if_rdata, d_rdata;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .b_taken(b_taken),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int unsigned m_busy;    // 0 none, 1 fetch outstanding, 2 data outstanding
  int unsigned m_wait;
  int unsigned m_streak;
  bit          m_cancel;
  bit          m_live = 1'b0;
  logic        m_req, m_we, m_ifv, m_dv, m_err;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
  logic [3:0]  m_be;

  always @(posedge clk) begin
    bit fetch_ok;
    fetch_ok = if_req && !b_taken;
    m_ifv <= 1'b0;
    m_dv  <= 1'b0;
    m_err <= 1'b0;
    if (rst) begin
      m_live <= 1'b1;  m_busy <= 0;  m_wait <= 0;  m_streak <= 0;  m_cancel <= 1'b0;
      m_req <= 1'b0;   m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;  m_be <= '0;
      m_ifr <= '0;     m_dr <= '0;
    end else if (m_busy == 0) begin
      if (d_req && !(fetch_ok && m_streak == MAXS)) begin
        m_busy <= 2; m_req <= 1'b1; m_we <= d_we; m_addr <= d_addr;
        m_wdata <= d_wdata; m_be <= d_be; m_wait <= 0; m_cancel <= 1'b0;
        m_streak <= if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (fetch_ok) begin
        m_busy <= 1; m_req <= 1'b1; m_we <= 1'b0; m_addr <= if_addr;
        m_wdata <= '0; m_be <= 4'hF; m_wait <= 0; m_cancel <= 1'b0; m_streak <= 0;
      end
    end else if (mem_ready) begin
      m_busy <= 0; m_req <= 1'b0; m_wait <= 0; m_cancel <= 1'b0;
      if (m_busy == 2) begin
        m_dv <= 1'b1; m_dr <= mem_rdata;
      end else if (!(m_cancel || b_taken)) begin
        m_ifv <= 1'b1; m_ifr <= mem_rdata;
      end
    end else if (m_wait + 1 == TMO) begin
      m_busy <= 0; m_req <= 1'b0; m_err <= 1'b1; m_wait <= 0; m_cancel <= 1'b0;
    end else begin
      m_wait <= m_wait + 1;
      if (m_busy == 1 && b_taken) m_cancel <= 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("mdl_mem_req",   32'(mem_req),   32'(m_req));
      chk("mdl_mem_we",    32'(mem_we),    32'(m_we));
      chk("mdl_mem_addr",  mem_addr,       m_addr);
      chk("mdl_mem_wdata", mem_wdata,      m_wdata);
      chk("mdl_mem_be",    32'(mem_be),    32'(m_be));
      chk("mdl_if_valid",  32'(if_valid),  32'(m_ifv));
      chk("mdl_if_rdata",  if_rdata,       m_ifr);
      chk("mdl_d_valid",   32'(d_valid),   32'(m_dv));
      chk("mdl_d_rdata",   d_rdata,        m_dr);
      chk("mdl_bus_err",   32'(bus_err),   32'(m_err));
      chk("mdl_stall_if",  32'(stall_if),
          32'(if_req && !(m_busy == 1 && mem_ready && !m_cancel && !b_taken && !rst)));
      chk("mdl_stall_mem", 32'(stall_mem),
          32'(d_req && !(m_busy == 2 && mem_ready && !rst)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int   hi;
    int   gi;
    int   err_cyc;
    int   err_cnt;
    logic g_kind [10];
    logic exp_kind [10];
    exp_kind = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; if_req = 1'b0; if_addr = '0; b_taken = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_be",  32'(mem_be), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b0;
    tick();

    // Fetch only, two wait cycles.
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("s1_stall_if_idle", 32'(stall_if), 1);
    tick(); hi = int'(mem_req);
    chk("s1_addr", mem_addr, 32'h100);
    chk("s1_be", 32'(mem_be), 32'hF);
    chk("s1_we", 32'(mem_we), 0);
    tick(); hi += int'(mem_req);
    chk("s1_stall_if_wait", 32'(stall_if), 1);
    tick(); hi += int'(mem_req);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0100;
    #1 chk("s1_stall_if_done", 32'(stall_if), 0);
    tick(); hi += int'(mem_req);
    chk("s1_if_valid", 32'(if_valid), 1);
    chk("s1_if_rdata", if_rdata, 32'hCAFE0100);
    chk("s1_req_cycles", 32'(hi), 3);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("s1_if_valid_drop", 32'(if_valid), 0);

    // Simultaneous fetch and load: data first, fetch right after.
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    tick();
    chk("s2_data_first", mem_addr, 32'h2000);
    chk("s2_stall_if", 32'(stall_if), 1);
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    #1 chk("s2_stall_mem_done", 32'(stall_mem), 0);
    chk("s2_stall_if_held", 32'(stall_if), 1);
    tick();
    chk("s2_d_valid", 32'(d_valid), 1);
    chk("s2_d_rdata", d_rdata, 32'h11112222);
    d_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk("s2_fetch_next", mem_addr, 32'h200);
    chk("s2_fetch_req", 32'(mem_req), 1);
    mem_ready = 1'b1; mem_rdata = 32'h33334444;
    tick();
    chk("s2_if_rdata", if_rdata, 32'h33334444);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Both held, zero-wait memory: four data grants then one fetch.
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_addr = 32'h3000; d_we = 1'b0; d_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    gi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_req) begin
        if (gi < 10) g_kind[gi] = (mem_addr == 32'h400);
        gi++;
      end
    end
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    chk("s3_grant_count", 32'(gi), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("s3_grant_%0d", i), 32'(g_kind[i]), 32'(exp_kind[i]));
    tick();

    // Branch cancels an in-flight fetch; the redirected fetch follows.
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    b_taken = 1'b1; if_addr = 32'h600;
    tick();
    b_taken = 1'b0;
    chk("s4_addr_held", mem_addr, 32'h500);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    #1 chk("s4_stall_cancel", 32'(stall_if), 1);
    tick();
    chk("s4_no_if_valid", 32'(if_valid), 0);
    chk("s4_idle_req", 32'(mem_req), 0);
    mem_ready = 1'b0;
    tick();
    chk("s4_refetch_addr", mem_addr, 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'h66666666;
    tick();
    chk("s4_refetch_valid", 32'(if_valid), 1);
    chk("s4_refetch_data", if_rdata, 32'h66666666);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Store that never completes: timeout.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h7000; d_wdata = 32'hA5A5A5A5; d_be = 4'b0011;
    tick();
    chk("s5_we", 32'(mem_we), 1);
    chk("s5_be", 32'(mem_be), 32'h3);
    chk("s5_wdata", mem_wdata, 32'hA5A5A5A5);
    hi = 1; err_cyc = -1; err_cnt = 0;
    for (int c = 2; c < 20; c++) begin
      tick();
      hi += int'(mem_req);
      if (bus_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
        d_req = 1'b0;
      end
      if (d_valid) chk("s5_no_d_valid", 32'(d_valid), 0);
    end
    chk("s5_err_edge_after_grant", 32'(err_cyc - 1), TMO);
    chk("s5_err_pulses", 32'(err_cnt), 1);
    chk("s5_req_cycles", 32'(hi), TMO);
    chk("s5_idle", 32'(mem_req), 0);

    // Reset in the middle of a load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000; d_be = 4'hF;
    tick();
    chk("s6_busy", 32'(mem_req), 1);
    rst = 1'b1; d_req = 1'b0;
    tick();
    chk("s6_mem_req", 32'(mem_req), 0);
    chk("s6_mem_we", 32'(mem_we), 0);
    chk("s6_mem_addr", mem_addr, 0);
    chk("s6_mem_wdata", mem_wdata, 0);
    chk("s6_mem_be", 32'(mem_be), 0);
    chk("s6_if_rdata", if_rdata, 0);
    chk("s6_d_rdata", d_rdata, 0);
    chk("s6_stalls", 32'({stall_if, stall_mem}), 0);
    rst = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h99999999;
    tick();
    chk("s6_no_d_valid", 32'(d_valid), 0);
    chk("s6_d_rdata_kept", d_rdata, 0);
    mem_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
